// File: rtl/nios2_ocimem_access_arbiter_pkg.sv
// rtl/nios2_ocimem_access_arbiter_pkg.sv - shared types and constants for the OCI RAM access arbiter
package nios2_ocimem_access_arbiter_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  // RD_* states are the cycle in which the RAM's registered read data is valid
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_JTAG = 2'd1,
    ST_RD_CPU  = 2'd2
  } state_e;

  localparam logic GRANT_CPU  = 1'b0;
  localparam logic GRANT_JTAG = 1'b1;

endpackage

// File: rtl/nios2_ocimem_access_arbiter_if.sv
// rtl/nios2_ocimem_access_arbiter_if.sv - JTAG, CPU Avalon and OCI RAM signal bundle
interface nios2_ocimem_access_arbiter_if
  import nios2_ocimem_access_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              jtag_set_addr;
  logic [ADDR_W-1:0] jtag_addr_in;
  logic              jtag_access;
  logic              jtag_write;
  logic [DATA_W-1:0] jtag_wdata;
  logic              jtag_clr_err;
  logic [DATA_W-1:0] mon_dreg;
  logic [ADDR_W-1:0] mon_areg;
  logic              monitor_ready;
  logic              monitor_error;

  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_writedata;
  logic [DATA_W-1:0] cpu_readdata;
  logic              cpu_waitrequest;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  jtag_set_addr, jtag_addr_in, jtag_access, jtag_write, jtag_wdata, jtag_clr_err,
    input  cpu_address, cpu_read, cpu_write, cpu_writedata, ram_rdata,
    output mon_dreg, mon_areg, monitor_ready, monitor_error,
    output cpu_readdata, cpu_waitrequest, ram_addr, ram_wren, ram_wdata
  );

  modport master (
    output jtag_set_addr, jtag_addr_in, jtag_access, jtag_write, jtag_wdata, jtag_clr_err,
    output cpu_address, cpu_read, cpu_write, cpu_writedata, ram_rdata,
    input  mon_dreg, mon_areg, monitor_ready, monitor_error,
    input  cpu_readdata, cpu_waitrequest, ram_addr, ram_wren, ram_wdata
  );

endinterface

// File: rtl/nios2_ocimem_rr_arbiter.sv
// rtl/nios2_ocimem_rr_arbiter.sv - two-way round-robin grant between CPU and JTAG
module nios2_ocimem_rr_arbiter
  import nios2_ocimem_access_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_cpu_i,
  input  logic req_jtag_i,
  input  logic enable_i,
  output logic gnt_cpu_o,
  output logic gnt_jtag_o
);

  // Reset to CPU so that JTAG wins the first tie
  logic last_grant_q, last_grant_d;

  // Grant the sole requester, or on a tie the one that was not served last
  always_comb begin
    gnt_cpu_o    = 1'b0;
    gnt_jtag_o   = 1'b0;
    last_grant_d = last_grant_q;
    if (enable_i) begin
      if (req_cpu_i && req_jtag_i) begin
        if (last_grant_q == GRANT_CPU) gnt_jtag_o = 1'b1;
        else                           gnt_cpu_o  = 1'b1;
      end else if (req_cpu_i) begin
        gnt_cpu_o = 1'b1;
      end else if (req_jtag_i) begin
        gnt_jtag_o = 1'b1;
      end
    end
    if (gnt_cpu_o)  last_grant_d = GRANT_CPU;
    if (gnt_jtag_o) last_grant_d = GRANT_JTAG;
  end

  // Remember who was served last
  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= GRANT_CPU;
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/nios2_ocimem_access_arbiter.sv
// rtl/nios2_ocimem_access_arbiter.sv - shares the OCI debug RAM between JTAG and the CPU slave port
module nios2_ocimem_access_arbiter
  import nios2_ocimem_access_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
)(
  input  logic                          clk,
  input  logic                          reset,
  nios2_ocimem_access_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  logic              jtag_pend_q, jtag_pend_d;
  logic              pend_write_q, pend_write_d;
  logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0] mon_areg_q, mon_areg_d;
  logic [DATA_W-1:0] mon_dreg_q, mon_dreg_d;
  logic              error_q, error_d;

  logic              cpu_req, arb_en, gnt_cpu, gnt_jtag;
  logic              cpu_done, jtag_done, jtag_accept;
  logic              ram_wren_c;
  logic [ADDR_W-1:0] ram_addr_c, acc_addr;
  logic [DATA_W-1:0] ram_wdata_c, cpu_rdata_c;

  // Simultaneous read and write is treated as a write
  assign cpu_req = bus.cpu_read | bus.cpu_write;
  assign arb_en  = (state_q == ST_IDLE) & ~reset;

  nios2_ocimem_rr_arbiter u_rr (
    .clk        (clk),
    .reset      (reset),
    .req_cpu_i  (cpu_req),
    .req_jtag_i (jtag_pend_q),
    .enable_i   (arb_en),
    .gnt_cpu_o  (gnt_cpu),
    .gnt_jtag_o (gnt_jtag)
  );

  // RAM sequencing: writes finish in the grant cycle, reads take one extra RD_* cycle
  always_comb begin
    state_d     = state_q;
    ram_addr_c  = '0;
    ram_wren_c  = 1'b0;
    ram_wdata_c = '0;
    cpu_done    = 1'b0;
    jtag_done   = 1'b0;
    cpu_rdata_c = '0;
    mon_dreg_d  = mon_dreg_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_cpu) begin
          ram_addr_c = bus.cpu_address;
          if (bus.cpu_write) begin
            ram_wren_c  = 1'b1;
            ram_wdata_c = bus.cpu_writedata;
            cpu_done    = 1'b1;
          end else begin
            state_d = ST_RD_CPU;
          end
        end else if (gnt_jtag) begin
          ram_addr_c = pend_addr_q;
          if (pend_write_q) begin
            ram_wren_c  = 1'b1;
            ram_wdata_c = pend_wdata_q;
            jtag_done   = 1'b1;
          end else begin
            state_d = ST_RD_JTAG;
          end
        end
      end
      ST_RD_JTAG: begin
        jtag_done  = 1'b1;
        mon_dreg_d = bus.ram_rdata;
        state_d    = ST_IDLE;
      end
      ST_RD_CPU: begin
        cpu_done    = 1'b1;
        cpu_rdata_c = bus.ram_rdata;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Nothing reaches the RAM or completes while reset is held
    if (reset) begin
      ram_addr_c  = '0;
      ram_wren_c  = 1'b0;
      ram_wdata_c = '0;
      cpu_done    = 1'b0;
      jtag_done   = 1'b0;
    end
  end

  // JTAG pending slot, address auto-increment and sticky overrun flag
  always_comb begin
    acc_addr     = bus.jtag_set_addr ? bus.jtag_addr_in : mon_areg_q;
    jtag_accept  = bus.jtag_access & (~jtag_pend_q | jtag_done);
    jtag_pend_d  = jtag_pend_q;
    pend_write_d = pend_write_q;
    pend_wdata_d = pend_wdata_q;
    pend_addr_d  = pend_addr_q;
    mon_areg_d   = mon_areg_q;
    if (jtag_accept) begin
      jtag_pend_d  = 1'b1;
      pend_write_d = bus.jtag_write;
      pend_wdata_d = bus.jtag_wdata;
      pend_addr_d  = acc_addr;
      mon_areg_d   = acc_addr + ADDR_W'(1);
    end else begin
      if (jtag_done)         jtag_pend_d = 1'b0;
      if (bus.jtag_set_addr) mon_areg_d  = bus.jtag_addr_in;
    end
    if (bus.jtag_access && !jtag_accept) error_d = 1'b1;
    else if (bus.jtag_clr_err)           error_d = 1'b0;
    else                                 error_d = error_q;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      jtag_pend_q  <= 1'b0;
      pend_write_q <= 1'b0;
      pend_wdata_q <= '0;
      pend_addr_q  <= '0;
      mon_areg_q   <= '0;
      mon_dreg_q   <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      jtag_pend_q  <= jtag_pend_d;
      pend_write_q <= pend_write_d;
      pend_wdata_q <= pend_wdata_d;
      pend_addr_q  <= pend_addr_d;
      mon_areg_q   <= mon_areg_d;
      mon_dreg_q   <= mon_dreg_d;
      error_q      <= error_d;
    end
  end

  assign bus.mon_dreg        = mon_dreg_q;
  assign bus.mon_areg        = mon_areg_q;
  assign bus.monitor_ready   = ~jtag_pend_q;
  assign bus.monitor_error   = error_q;
  assign bus.cpu_readdata    = cpu_rdata_c;
  assign bus.cpu_waitrequest = cpu_req & ~cpu_done;
  assign bus.ram_addr        = ram_addr_c;
  assign bus.ram_wren        = ram_wren_c;
  assign bus.ram_wdata       = ram_wdata_c;

endmodule

// File: tb/tb_nios2_ocimem_access_arbiter.sv
// tb/tb_nios2_ocimem_access_arbiter.sv - self-checking bench for the OCI RAM access arbiter
module tb_nios2_ocimem_access_arbiter;

  logic clk;
  logic reset;
  logic mem_init;
  int   n_pass;
  int   n_total;

  nios2_ocimem_access_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  nios2_ocimem_access_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // OCI RAM: one-cycle registered read, background pattern A500_00xx
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (bus.ram_wren) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct {
    logic rst, sa; logic [7:0] ain; logic acc, wr; logic [31:0] wd; logic clr;
    logic crd, cwr; logic [7:0] caddr; logic [31:0] cwd;
    logic ewren; logic [7:0] eaddr; logic [31:0] ewdata; logic ewait; logic [31:0] erdata;
    logic eready, eerr; logic [7:0] eareg; logic [31:0] edreg;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] shadow [256];

  task automatic add(input logic rst, sa, input logic [7:0] ain, input logic acc, wr,
                     input logic [31:0] wd, input logic clr, crd, cwr, input logic [7:0] caddr,
                     input logic [31:0] cwd, input logic ewren, input logic [7:0] eaddr,
                     input logic [31:0] ewdata, input logic ewait, input logic [31:0] erdata,
                     input logic eready, eerr, input logic [7:0] eareg, input logic [31:0] edreg);
    vec_t v;
    v.rst = rst; v.sa = sa; v.ain = ain; v.acc = acc; v.wr = wr; v.wd = wd; v.clr = clr;
    v.crd = crd; v.cwr = cwr; v.caddr = caddr; v.cwd = cwd;
    v.ewren = ewren; v.eaddr = eaddr; v.ewdata = ewdata; v.ewait = ewait; v.erdata = erdata;
    v.eready = eready; v.eerr = eerr; v.eareg = eareg; v.edreg = edreg;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.jtag_set_addr = 0; bus.jtag_addr_in = 0; bus.jtag_access = 0; bus.jtag_write = 0;
    bus.jtag_wdata = 0; bus.jtag_clr_err = 0;
    bus.cpu_address = 0; bus.cpu_read = 0; bus.cpu_write = 0; bus.cpu_writedata = 0;
  endtask

  // Random CPU traffic in 0x00-0x7F, checked against the shadow memory and latency bound
  task automatic cpu_random(input int n);
    logic [7:0]  a;
    logic        w, done;
    logic [31:0] d;
    int          lat;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) cyc();
      a = 8'($urandom_range(0, 127)); w = 1'($urandom_range(0, 1)); d = $urandom;
      bus.cpu_address = a; bus.cpu_write = w; bus.cpu_read = ~w; bus.cpu_writedata = d;
      lat = 0; done = 0;
      while (!done && lat < 8) begin
        #2;
        lat++;
        if (!bus.cpu_waitrequest) begin
          done = 1;
          if (w) shadow[a] = d;
          else   chk($sformatf("cpu_rand_rdata[%0h]", a), bus.cpu_readdata, shadow[a]);
        end
        cyc();
      end
      bus.cpu_read = 0; bus.cpu_write = 0;
      chk("cpu_rand_done", 32'(done), 32'd1);
      chk("cpu_rand_latency_le4", 32'(lat <= 4), 32'd1);
    end
  endtask

  // Random JTAG traffic in 0x80-0xFE, one access at a time with an explicit address
  task automatic jtag_random(input int n);
    logic [7:0]  a;
    logic        w;
    logic [31:0] d;
    int          t;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) cyc();
      a = 8'($urandom_range(128, 254)); w = 1'($urandom_range(0, 1)); d = $urandom;
      bus.jtag_set_addr = 1; bus.jtag_addr_in = a; bus.jtag_access = 1;
      bus.jtag_write = w; bus.jtag_wdata = d;
      cyc();
      bus.jtag_set_addr = 0; bus.jtag_access = 0; bus.jtag_write = 0;
      chk("jtag_rand_areg", 32'(bus.mon_areg), 32'(a) + 32'd1);
      t = 0;
      while (!bus.monitor_ready && t < 12) begin cyc(); t++; end
      chk("jtag_rand_ready", 32'(bus.monitor_ready), 32'd1);
      if (w) shadow[a] = d;
      else   chk($sformatf("jtag_rand_dreg[%0h]", a), bus.mon_dreg, shadow[a]);
    end
  endtask

  initial begin
    vec_t v;
    n_pass = 0; n_total = 0;
    idle_inputs();
    reset = 1; mem_init = 1;
    cyc(); cyc();
    reset = 0; mem_init = 0;
    #2;
    chk("reset mon_dreg", bus.mon_dreg, 32'h0);
    chk("reset mon_areg", 32'(bus.mon_areg), 32'h0);
    chk("reset monitor_ready", 32'(bus.monitor_ready), 32'h1);
    chk("reset monitor_error", 32'(bus.monitor_error), 32'h0);
    chk("reset ram_wren", 32'(bus.ram_wren), 32'h0);
    chk("reset ram_addr", 32'(bus.ram_addr), 32'h0);
    chk("reset ram_wdata", bus.ram_wdata, 32'h0);
    chk("reset waitrequest", 32'(bus.cpu_waitrequest), 32'h0);
    cyc();

    // rst sa ain acc wr wd clr | crd cwr caddr cwd | ewren eaddr ewdata ewait erdata eready eerr eareg edreg
    // JTAG write 0x10 then read it back
    add(0,1,'h10,0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,0,'h00,0);
    add(0,0,0,1,1,'hDEADBEEF,0, 0,0,0,0, 0,0,0,0,0,1,0,'h10,0);
    add(0,0,0,0,0,0,0, 0,0,0,0, 1,'h10,'hDEADBEEF,0,0,0,0,'h11,0);
    add(0,1,'h10,1,0,0,0, 0,0,0,0, 0,0,0,0,0,1,0,'h11,0);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,'h10,0,0,0,0,0,'h11,0);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,'h11,0);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,0,'h11,'hDEADBEEF);
    // auto-increment wrap 0xFF -> 0x00
    add(0,1,'hFF,1,0,0,0, 0,0,0,0, 0,0,0,0,0,1,0,'h11,'hDEADBEEF);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,'hFF,0,0,0,0,0,'h00,'hDEADBEEF);
    add(0,0,0,1,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,'h00,'hDEADBEEF);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,'h00,0,0,0,0,0,'h01,'hA50000FF);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,'h01,'hA50000FF);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,0,'h01,'hA5000000);
    // reset, then contention: JTAG wins first tie, CPU data on its 4th cycle
    add(1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,0,'h01,'hA5000000);
    add(0,1,'h30,1,0,0,0, 0,0,0,0, 0,0,0,0,0,1,0,'h00,0);
    add(0,0,0,0,0,0,0, 1,0,'h20,0, 0,'h30,0,1,0,0,0,'h31,0);
    add(0,0,0,0,0,0,0, 1,0,'h20,0, 0,0,0,1,0,0,0,'h31,0);
    add(0,0,0,0,0,0,0, 1,0,'h20,0, 0,'h20,0,1,0,1,0,'h31,'hA5000030);
    add(0,0,0,0,0,0,0, 1,0,'h20,0, 0,0,0,0,'hA5000020,1,0,'h31,'hA5000030);
    // tie after a JTAG grant goes to the CPU
    add(0,1,'h40,1,0,0,0, 0,0,0,0, 0,0,0,0,0,1,0,'h31,'hA5000030);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,'h40,0,0,0,0,0,'h41,'hA5000030);
    add(0,1,'h50,1,0,0,0, 1,0,'h22,0, 0,0,0,1,0,0,0,'h41,'hA5000030);
    add(0,0,0,0,0,0,0, 1,0,'h22,0, 0,'h22,0,1,0,0,0,'h51,'hA5000040);
    add(0,0,0,0,0,0,0, 1,0,'h22,0, 0,0,0,0,'hA5000022,0,0,'h51,'hA5000040);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,'h50,0,0,0,0,0,'h51,'hA5000040);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,'h51,'hA5000040);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,0,'h51,'hA5000050);
    // overrun while the CPU holds the RAM; clear
    add(0,0,0,1,0,0,0, 1,0,'h23,0, 0,'h23,0,1,0,1,0,'h51,'hA5000050);
    add(0,0,0,1,0,0,0, 1,0,'h23,0, 0,0,0,0,'hA5000023,0,0,'h52,'hA5000050);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,'h51,0,0,0,0,1,'h52,'hA5000050);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,1,'h52,'hA5000050);
    add(0,0,0,0,0,0,1, 0,0,0,0, 0,0,0,0,0,1,1,'h52,'hA5000051);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,0,'h52,'hA5000051);
    // CPU write without stall, read back with one wait cycle
    add(0,0,0,0,0,0,0, 0,1,'h05,'h12345678, 1,'h05,'h12345678,0,0,1,0,'h52,'hA5000051);
    add(0,0,0,0,0,0,0, 1,0,'h05,0, 0,'h05,0,1,0,1,0,'h52,'hA5000051);
    add(0,0,0,0,0,0,0, 1,0,'h05,0, 0,0,0,0,'h12345678,1,0,'h52,'hA5000051);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,0,'h52,'hA5000051);
    // reset during RD_JTAG drops the pending read
    add(0,1,'h60,1,0,0,0, 0,0,0,0, 0,0,0,0,0,1,0,'h52,'hA5000051);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,'h60,0,0,0,0,0,'h61,'hA5000051);
    add(1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,'h61,'hA5000051);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,0,'h00,0);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,0,'h00,0);
    // CPU write during reset never reaches the RAM
    add(1,0,0,0,0,0,0, 0,1,'h06,'h0BADF00D, 0,0,0,1,0,1,0,'h00,0);
    add(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,0,'h00,0);
    add(0,0,0,0,0,0,0, 1,0,'h06,0, 0,'h06,0,1,0,1,0,'h00,0);
    add(0,0,0,0,0,0,0, 1,0,'h06,0, 0,0,0,0,'hA5000006,1,0,'h00,0);

    foreach (vecs[i]) begin
      v = vecs[i];
      reset = v.rst;
      bus.jtag_set_addr = v.sa; bus.jtag_addr_in = v.ain; bus.jtag_access = v.acc;
      bus.jtag_write = v.wr; bus.jtag_wdata = v.wd; bus.jtag_clr_err = v.clr;
      bus.cpu_read = v.crd; bus.cpu_write = v.cwr; bus.cpu_address = v.caddr;
      bus.cpu_writedata = v.cwd;
      #2;
      chk($sformatf("r%0d ram_wren", i), 32'(bus.ram_wren), 32'(v.ewren));
      chk($sformatf("r%0d ram_addr", i), 32'(bus.ram_addr), 32'(v.eaddr));
      if (v.ewren) chk($sformatf("r%0d ram_wdata", i), bus.ram_wdata, v.ewdata);
      chk($sformatf("r%0d waitrequest", i), 32'(bus.cpu_waitrequest), 32'(v.ewait));
      if (v.crd && !v.ewait) chk($sformatf("r%0d cpu_readdata", i), bus.cpu_readdata, v.erdata);
      chk($sformatf("r%0d monitor_ready", i), 32'(bus.monitor_ready), 32'(v.eready));
      chk($sformatf("r%0d monitor_error", i), 32'(bus.monitor_error), 32'(v.eerr));
      chk($sformatf("r%0d mon_areg", i), 32'(bus.mon_areg), 32'(v.eareg));
      chk($sformatf("r%0d mon_dreg", i), bus.mon_dreg, v.edreg);
      cyc();
    end

    idle_inputs();
    reset = 1; mem_init = 1;
    cyc();
    reset = 0; mem_init = 0;
    for (int i = 0; i < 256; i++) shadow[i] = 32'hA500_0000 | 32'(i);
    cyc();
    fork
      cpu_random(60);
      jtag_random(40);
    join
    #2;
    chk("rand monitor_error", 32'(bus.monitor_error), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nios2_ocimem_access_arbiter.md
Name: nios2_ocimem_access_arbiter

Overview:
- Sequences and shares the single-port on-chip debug memory (OCI RAM, 2^ADDR_W x DATA_W, 1-cycle registered read) between two requesters:
  - the JTAG debug path, which issues take_action pulses in the sysclk domain;
  - the CPU monitor-side Avalon-MM slave port.
- Owns the debug address register (auto-increment) and the debug data register.
- Provides ready/error status back to the JTAG shift logic.

Parameters:
- ADDR_W, 8, OCI RAM word-address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- jtag_set_addr  in  1  pulse: load debug address register from jtag_addr_in.
- jtag_addr_in  in  ADDR_W  new debug address.
- jtag_access  in  1  pulse: request one OCI RAM access at the debug address.
- jtag_write  in  1  qualifies jtag_access: 1 = write, 0 = read.
- jtag_wdata  in  DATA_W  write data for jtag_access.
- jtag_clr_err  in  1  pulse: clear sticky overrun flag.
- mon_dreg  out  DATA_W  last JTAG read result.
- mon_areg  out  ADDR_W  current debug address register.
- monitor_ready  out  1  level: no JTAG access outstanding.
- monitor_error  out  1  sticky overrun flag.
- cpu_address  in  ADDR_W  Avalon address.
- cpu_read  in  1  Avalon read.
- cpu_write  in  1  Avalon write.
- cpu_writedata  in  DATA_W  Avalon write data.
- cpu_readdata  out  DATA_W  Avalon read data, valid when read and waitrequest low.
- cpu_waitrequest  out  1  Avalon stall (combinational).
- ram_addr  out  ADDR_W  OCI RAM address.
- ram_wren  out  1  OCI RAM write enable.
- ram_wdata  out  DATA_W  OCI RAM write data.
- ram_rdata  in  DATA_W  OCI RAM read data, one cycle after address.

Behaviour:
- Reset values:
  - FSM = IDLE, jtag_pend = 0, last_grant = CPU (JTAG wins the first tie).
  - mon_dreg = 0, mon_areg = 0, monitor_ready = 1, monitor_error = 0.
  - ram_wren = 0, ram_addr = 0, ram_wdata = 0.
- Reset mid-operation: the in-flight access is abandoned. ram_wren is low from the reset cycle onward. Any pending JTAG request is dropped.
- JTAG acceptance:
  - When jtag_access = 1 and (jtag_pend = 0 or the pending access completes this cycle):
    - latch {write, wdata, addr = mon_areg} into the pending slot;
    - set jtag_pend = 1 and monitor_ready = 0;
    - mon_areg <= mon_areg + 1, wrapping 2^ADDR_W-1 -> 0.
  - With jtag_set_addr in the same cycle, the access uses jtag_addr_in and mon_areg <= jtag_addr_in + 1.
  - jtag_set_addr alone: mon_areg <= jtag_addr_in. An already-pending access keeps its latched address.
- JTAG overrun: jtag_access while a pending access is not completing -> request dropped, monitor_error <= 1 (sticky). jtag_clr_err clears it; if set and clear coincide, set wins.
- CPU request: present while cpu_read | cpu_write. Both asserted is illegal; treat as a write.
- FSM states: IDLE, RD_JTAG, RD_CPU.
- IDLE grant:
  - If only one requester is present, grant it.
  - If both are present, grant the one not equal to last_grant.
  - On grant, last_grant is updated.
- Write grant:
  - drive ram_addr/ram_wdata with ram_wren = 1 registered (RAM sees it the next edge); FSM stays in IDLE;
  - CPU: waitrequest low in the grant cycle;
  - JTAG: jtag_pend clears and monitor_ready = 1 from the next cycle.
- Read grant:
  - drive ram_addr and move to RD_JTAG or RD_CPU.
  - Next cycle, ram_rdata is valid:
    - RD_CPU: cpu_readdata = ram_rdata and waitrequest low in this cycle.
    - RD_JTAG: mon_dreg <= ram_rdata, jtag_pend clears, monitor_ready = 1.
  - Then return to IDLE.
  - No back-to-back read issue: the RAM is idle during RD_*.
- cpu_waitrequest = (cpu_read | cpu_write) & ~cpu_done_this_cycle. It is 0 when there is no request.
- Fairness: a waiting requester is served after at most one opposing transaction. Worst-case CPU read latency is 4 cycles.

Decomposition:
- Shared package holds:
  - FSM state enum {IDLE, RD_JTAG, RD_CPU};
  - grant encoding localparams GRANT_CPU / GRANT_JTAG;
  - default ADDR_W/DATA_W constants.
- One natural sub-module: nios2_ocimem_rr_arbiter, a 2-way round-robin grant with last_grant register.

Test Plan:
- JTAG write then read:
  - stimulus: set_addr 0x10; access write 0xDEADBEEF; access read after set_addr 0x10;
  - response: ram_wren at addr 0x10; mon_dreg = 0xDEADBEEF; mon_areg = 0x11; monitor_ready low exactly 2 cycles for the read.
- Auto-increment wrap: set_addr 0xFF, two reads -> RAM addresses 0xFF then 0x00; mon_areg = 0x01.
- Contention: CPU read 0x20 and JTAG read 0x30 in the same IDLE cycle after reset -> JTAG served first; CPU waitrequest low on cycle 4 with data from 0x20; next tie grants CPU.
- Overrun: jtag_access read, then another jtag_access the next cycle while CPU holds the RAM in RD_CPU -> second dropped; monitor_error = 1 until jtag_clr_err; mon_areg advanced once only.
- CPU write: cpu_write 0x05 / 0x12345678 with no JTAG traffic -> waitrequest never high; ram_wren one cycle; a subsequent CPU read returns 0x12345678 with 1 wait cycle.
- Reset mid-read: reset asserted in RD_JTAG -> next cycle FSM IDLE, monitor_ready = 1, mon_dreg = 0, ram_wren = 0, pending dropped.
